// File: rtl/vad_feat_binarize.sv
// -----------------------------------------------------------------------------
// vad_feat_binarize
//
// Front-end feature binarizer for the BNN voice-activity-detection core.
// A stream of unsigned per-band energy samples arrives over a valid/ready
// handshake, NBAND samples per frame. Each sample is compared against a
// per-band exponential moving average (EMA) of that band's history; the
// comparison bit is packed into an NBAND-bit frame word. When a well-formed
// frame completes, the word is presented on data_in together with a
// one-cycle read_en strobe, which drives the VAD core's input port directly.
//
// Parameters
//   DW     width of an unsigned band energy sample
//   NBAND  bands per frame, and width of the packed frame word (>= 2)
//   SHIFT  EMA smoothing shift, alpha = 2^-SHIFT (1 .. DW-1)
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous: zero every EMA and abandon the current frame
//   in_valid   sample valid
//   in_ready   block can accept a sample this cycle
//   in_data    unsigned band energy
//   in_last    marks the final band of a frame (qualified by in_valid)
//   read_en    one-cycle strobe: data_in holds a freshly completed frame
//   data_in    packed binary frame, band 0 in the MSB
//   frame_err  one-cycle pulse: a malformed frame was discarded
// -----------------------------------------------------------------------------
module vad_feat_binarize #(
    parameter int DW    = 16,
    parameter int NBAND = 20,
    parameter int SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             in_last,
    output logic             read_en,
    output logic [NBAND-1:0] data_in,
    output logic             frame_err
);

    localparam int CW = (NBAND > 1) ? $clog2(NBAND) : 1;
    localparam logic [CW-1:0] LAST_BAND = CW'(NBAND - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    bandCnt_q, bandCnt_d;
    logic [NBAND-1:0] frameShift_q, frameShift_d;
    logic [NBAND-1:0] frameOut_q, frameOut_d;
    logic             frameErr_q, frameErr_d;
    logic             live_q;
    logic [DW-1:0]    ema_q [NBAND];

    logic             accept;
    logic             sampleBit;
    logic             isLastBand;
    logic             frameDone;
    logic             frameBad;
    logic [NBAND-1:0] shiftedIn;
    logic [DW-1:0]    emaCur;
    logic [DW-1:0]    emaNext;
    logic signed [DW:0] emaDiff;
    logic [DW-1:0]    emaStep;

    // live_q holds in_ready low while in reset and for nothing else: it
    // rises on the first clock edge after rst_n is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Handshake and per-sample datapath. A clear in the same cycle blocks
    // acceptance, so a sample offered alongside clear is simply retried.
    always_comb begin
        in_ready   = live_q & (state_q == COLLECT) & ~clear;
        accept     = in_ready & in_valid;
        emaCur     = ema_q[bandCnt_q];
        sampleBit  = (in_data > emaCur);
        isLastBand = (bandCnt_q == LAST_BAND);
        frameDone  = accept & isLastBand & in_last;
        frameBad   = accept & (isLastBand ^ in_last);
        shiftedIn  = {frameShift_q[NBAND-2:0], sampleBit};
    end

    // EMA update: ema += floor((x - ema) / 2^SHIFT). The difference is
    // formed as a signed DW+1-bit value so the arithmetic shift floors
    // toward minus infinity. The mathematically exact result always lies
    // between ema and x, so it fits in DW bits and modulo-2^DW addition of
    // the truncated step gives the exact answer.
    always_comb begin
        emaDiff = $signed({1'b0, in_data}) - $signed({1'b0, emaCur});
        emaStep = DW'(emaDiff >>> SHIFT);
        emaNext = emaCur + emaStep;
    end

    // Per-band EMA bank. Only the band currently addressed by the counter
    // moves, and it moves for every accepted sample, including the one that
    // makes a frame malformed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBAND; i++) begin
                ema_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NBAND; i++) begin
                ema_q[i] <= '0;
            end
        end else if (accept) begin
            ema_q[bandCnt_q] <= emaNext;
        end
    end

    // Control: band counter, frame assembly and the COLLECT/EMIT sequence.
    // The output word only changes when a well-formed frame completes; an
    // error, a clear or idle cycles leave it untouched.
    always_comb begin
        state_d      = state_q;
        bandCnt_d    = bandCnt_q;
        frameShift_d = frameShift_q;
        frameOut_d   = frameOut_q;
        frameErr_d   = 1'b0;

        if (clear) begin
            state_d      = COLLECT;
            bandCnt_d    = '0;
            frameShift_d = '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (frameDone) begin
                        frameOut_d   = shiftedIn;
                        frameShift_d = '0;
                        bandCnt_d    = '0;
                        state_d      = EMIT;
                    end else if (frameBad) begin
                        frameShift_d = '0;
                        bandCnt_d    = '0;
                        frameErr_d   = 1'b1;
                    end else if (accept) begin
                        frameShift_d = shiftedIn;
                        bandCnt_d    = bandCnt_q + 1'b1;
                    end
                end
                EMIT: begin
                    state_d = COLLECT;
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            bandCnt_q    <= '0;
            frameShift_q <= '0;
            frameOut_q   <= '0;
            frameErr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bandCnt_q    <= bandCnt_d;
            frameShift_q <= frameShift_d;
            frameOut_q   <= frameOut_d;
            frameErr_q   <= frameErr_d;
        end
    end

    // read_en is high exactly for the single EMIT cycle; frame_err can only
    // be set from COLLECT without entering EMIT, so the two never overlap.
    always_comb begin
        read_en   = (state_q == EMIT);
        data_in   = frameOut_q;
        frame_err = frameErr_q;
    end

endmodule

// File: tb/tb_vad_feat_binarize.sv
// -----------------------------------------------------------------------------
// tb_vad_feat_binarize
//
// Self-checking bench for vad_feat_binarize. Stimulus is a linear sequence of
// directed steps, mixing fixed frames with $urandom data and idle gaps. A
// reference model kept here tracks the per-band averages with plain integer
// arithmetic, the band position, the expected frame word and the expected
// strobes, and every DUT output is compared against it.
// -----------------------------------------------------------------------------
module tb_vad_feat_binarize;

    localparam int DW    = 16;
    localparam int NBAND = 20;
    localparam int SHIFT = 3;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             in_last;
    logic             read_en;
    logic [NBAND-1:0] data_in;
    logic             frame_err;

    vad_feat_binarize #(
        .DW   (DW),
        .NBAND(NBAND),
        .SHIFT(SHIFT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .read_en  (read_en),
        .data_in  (data_in),
        .frame_err(frame_err)
    );

    // 100 MHz style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passCount = 0;
    int checkCount = 0;

    // Reference model state.
    int               emaM [NBAND];
    int               bandM;
    logic [NBAND-1:0] bitsM;
    logic [NBAND-1:0] expData;
    logic [DW-1:0]    frameVals [NBAND];

    // Floor division by 2^SHIFT on a signed integer.
    function automatic int floorShift(input int v);
        int den;
        den = 1 << SHIFT;
        if (v >= 0) return v / den;
        return -((-v + den - 1) / den);
    endfunction

    task automatic modelReset(input logic wipeOutput);
        for (int i = 0; i < NBAND; i++) emaM[i] = 0;
        bandM = 0;
        bitsM = '0;
        if (wipeOutput) expData = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Offer one sample after an optional random idle gap, then compare the
    // strobes, the held frame word and in_ready against the model.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic l, input int gapMax);
        int  gap;
        int  waitBudget;
        logic bitM;
        logic expEmit;
        logic expErr;
        gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            in_last  = 1'($urandom);
        end
        @(negedge clk);
        waitBudget = 0;
        while (in_ready !== 1'b1 && waitBudget < 8) begin
            @(negedge clk);
            waitBudget++;
        end
        checkOutput("ready_before_sample", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_last  = 1'($urandom);

        bitM = (int'(d) > emaM[bandM]);
        emaM[bandM] = emaM[bandM] + floorShift(int'(d) - emaM[bandM]);
        bitsM   = {bitsM[NBAND-2:0], bitM};
        expEmit = (bandM == NBAND - 1) && l;
        expErr  = (bandM == NBAND - 1) != l;
        if (expEmit) expData = bitsM;
        bandM = (expEmit || expErr) ? 0 : bandM + 1;

        checkOutput("read_en", {31'b0, read_en}, {31'b0, expEmit});
        checkOutput("frame_err", {31'b0, frame_err}, {31'b0, expErr});
        checkOutput("data_in", {12'b0, data_in}, {12'b0, expData});
        checkOutput("in_ready_after", {31'b0, in_ready}, {31'b0, !expEmit});
        if (expEmit || expErr) begin
            @(posedge clk);
            #1;
            checkOutput("read_en_drop", {31'b0, read_en}, 32'd0);
            checkOutput("frame_err_drop", {31'b0, frame_err}, 32'd0);
            checkOutput("in_ready_back", {31'b0, in_ready}, 32'd1);
            checkOutput("data_in_hold", {12'b0, data_in}, {12'b0, expData});
        end
    endtask

    task automatic sendFrame(input int gapMax);
        for (int i = 0; i < NBAND; i++) begin
            applyStimulus(frameVals[i], (i == NBAND - 1), gapMax);
        end
    endtask

    task automatic randomValues();
        for (int i = 0; i < NBAND; i++) begin
            case ($urandom_range(0, 3))
                0:       frameVals[i] = '0;
                1:       frameVals[i] = '1;
                default: frameVals[i] = DW'($urandom);
            endcase
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        modelReset(1'b1);

        // Reset values.
        #12;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("rst_read_en", {31'b0, read_en}, 32'd0);
        checkOutput("rst_frame_err", {31'b0, frame_err}, 32'd0);
        checkOutput("rst_data_in", {12'b0, data_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_release", {31'b0, in_ready}, 32'd1);

        // All bands at 100 from zero averages: every bit set.
        for (int i = 0; i < NBAND; i++) frameVals[i] = 16'd100;
        sendFrame(0);
        checkOutput("frame1_all_ones", {12'b0, data_in}, 32'h000FFFFF);

        // Band 0 drops below its average, the rest rise above.
        frameVals[0] = 16'd4;
        for (int i = 1; i < NBAND; i++) frameVals[i] = 16'd100;
        sendFrame(0);
        checkOutput("frame2_band0_low", {12'b0, data_in}, 32'h0007FFFF);

        // Samples equal to the averages: strict compare gives all zeros.
        for (int i = 0; i < NBAND; i++) frameVals[i] = DW'(emaM[i]);
        sendFrame(0);
        checkOutput("frame3_equal", {12'b0, data_in}, 32'h00000000);

        // Early in_last on the 7th sample, then a clean random frame.
        for (int i = 0; i < 7; i++) applyStimulus(DW'($urandom), (i == 6), 0);
        randomValues();
        sendFrame(0);

        // Missing in_last on the 20th sample.
        for (int i = 0; i < NBAND; i++) applyStimulus(DW'($urandom), 1'b0, 0);

        // Well-formed frames with random idle gaps, including boundary values.
        for (int f = 0; f < 5; f++) begin
            randomValues();
            sendFrame(3);
        end

        // Clear after ten samples; a sample offered with clear is refused.
        for (int i = 0; i < 10; i++) applyStimulus(DW'($urandom), 1'b0, 1);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_last  = 1'b0;
        #1;
        checkOutput("ready_during_clear", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        modelReset(1'b0);
        checkOutput("clear_read_en", {31'b0, read_en}, 32'd0);
        checkOutput("clear_frame_err", {31'b0, frame_err}, 32'd0);
        checkOutput("clear_data_hold", {12'b0, data_in}, {12'b0, expData});
        for (int i = 0; i < NBAND; i++) frameVals[i] = 16'd1;
        sendFrame(0);
        checkOutput("after_clear_ones", {12'b0, data_in}, 32'h000FFFFF);

        // Asynchronous reset pulse in the middle of a frame.
        for (int i = 0; i < 8; i++) applyStimulus(DW'($urandom), 1'b0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset(1'b1);
        checkOutput("midrst_data_in", {12'b0, data_in}, 32'd0);
        checkOutput("midrst_read_en", {31'b0, read_en}, 32'd0);
        checkOutput("midrst_frame_err", {31'b0, frame_err}, 32'd0);
        checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_ready_back", {31'b0, in_ready}, 32'd1);
        randomValues();
        sendFrame(2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
